// File: rtl/lcd_frame_writer_pkg.sv
// Shared definitions for the LCD frame writer: opcodes, state encoding and the bar colour table.
package lcd_frame_writer_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_CASET_C = 4'd1;
    localparam state_t S_CASET_D = 4'd2;
    localparam state_t S_RASET_C = 4'd3;
    localparam state_t S_RASET_D = 4'd4;
    localparam state_t S_RAMWR_C = 4'd5;
    localparam state_t S_PIX_HI  = 4'd6;
    localparam state_t S_PIX_LO  = 4'd7;
    localparam state_t S_DONE    = 4'd8;

    // RGB565: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR_COLORS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        return BAR_COLORS[idx];
    endfunction

    // Window parameters go out as start[15:8], start[7:0], end[15:8], end[7:0].
    function automatic logic [7:0] param_byte(input logic [1:0] idx,
                                              input logic [15:0] first,
                                              input logic [15:0] last);
        case (idx)
            2'd0:    return first[15:8];
            2'd1:    return first[7:0];
            2'd2:    return last[15:8];
            default: return last[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_writer_scan.sv
// Column/row/bar position tracker for the pixel stream; advances one pixel per step.
module lcd_pixel_scan #(
    parameter int H_RES = 240,
    parameter int V_RES = 280
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic       clear_i,
    output logic [2:0] bar_o,
    output logic       last_o
);

    localparam int CW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int RW    = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int BAR_W = (H_RES >= 8) ? H_RES / 8 : 1;
    localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);
    localparam logic [SW-1:0] SEG_LAST = SW'(BAR_W - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [2:0]    bar_q, bar_d;

    // seg counts columns within the current bar so no divider is needed.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        seg_d = seg_q;
        bar_d = bar_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
            seg_d = '0;
            bar_d = '0;
        end else if (step_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
                seg_d = '0;
                bar_d = '0;
            end else begin
                col_d = col_q + CW'(1);
                if (seg_q == SEG_LAST) begin
                    seg_d = '0;
                    if (bar_q != 3'd7) begin
                        bar_d = bar_q + 3'd1;
                    end
                end else begin
                    seg_d = seg_q + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            seg_q <= '0;
            bar_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            seg_q <= seg_d;
            bar_q <= bar_d;
        end
    end

    assign bar_o  = bar_q;
    assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/lcd_frame_writer.sv
// Streams one full LCD frame (CASET, RASET, RAMWR, then RGB565 pixels) as bytes into a FIFO.
module lcd_frame_writer
    import lcd_frame_writer_pkg::*;
#(
    parameter int H_RES = 240,
    parameter int V_RES = 280,
    parameter int Y_OFS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pattern,
    input  logic [15:0] color,
    output logic        valid,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        is_cmd,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state_dbg
);

    localparam logic [15:0] COL_END   = 16'(H_RES - 1);
    localparam logic [15:0] ROW_START = 16'(Y_OFS);
    localparam logic [15:0] ROW_END   = 16'(Y_OFS + V_RES - 1);

    state_t      state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        pattern_q, pattern_d;
    logic [15:0] color_q, color_d;
    logic [15:0] pix_color;
    logic [2:0]  bar;
    logic        last_pix;
    logic        scan_step, scan_clear;
    logic        xfer;

    // Handshake: a byte moves only when valid && ready on a rising edge; valid,
    // data and is_cmd are pure functions of registered state, so they stay put
    // until that transfer and the next byte is offered the very next cycle.
    always_comb begin
        valid     = 1'b0;
        data      = 8'h00;
        is_cmd    = 1'b0;
        pix_color = pattern_q ? bar_color(bar) : color_q;
        case (state_q)
            S_CASET_C: begin valid = 1'b1; data = CMD_CASET; is_cmd = 1'b1; end
            S_CASET_D: begin valid = 1'b1; data = param_byte(pidx_q, 16'h0000, COL_END); end
            S_RASET_C: begin valid = 1'b1; data = CMD_RASET; is_cmd = 1'b1; end
            S_RASET_D: begin valid = 1'b1; data = param_byte(pidx_q, ROW_START, ROW_END); end
            S_RAMWR_C: begin valid = 1'b1; data = CMD_RAMWR; is_cmd = 1'b1; end
            S_PIX_HI:  begin valid = 1'b1; data = pix_color[15:8]; end
            S_PIX_LO:  begin valid = 1'b1; data = pix_color[7:0]; end
            default:   ;
        endcase
    end

    assign xfer = valid && ready;

    always_comb begin
        state_d    = state_q;
        pidx_d     = pidx_q;
        pattern_d  = pattern_q;
        color_d    = color_q;
        scan_step  = 1'b0;
        scan_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CASET_C;
                    pattern_d = pattern;
                    color_d   = color;
                end
            end
            S_CASET_C: if (xfer) state_d = S_CASET_D;
            S_CASET_D: begin
                if (xfer) begin
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) state_d = S_RASET_C;
                end
            end
            S_RASET_C: if (xfer) state_d = S_RASET_D;
            S_RASET_D: begin
                if (xfer) begin
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) state_d = S_RAMWR_C;
                end
            end
            S_RAMWR_C: if (xfer) state_d = S_PIX_HI;
            S_PIX_HI:  if (xfer) state_d = S_PIX_LO;
            S_PIX_LO: begin
                if (xfer) begin
                    if (last_pix) begin
                        state_d    = S_DONE;
                        scan_clear = 1'b1;
                    end else begin
                        state_d   = S_PIX_HI;
                        scan_step = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pidx_q    <= 2'd0;
            pattern_q <= 1'b0;
            color_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pidx_q    <= pidx_d;
            pattern_q <= pattern_d;
            color_q   <= color_d;
        end
    end

    lcd_pixel_scan #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .step_i (scan_step),
        .clear_i(scan_clear),
        .bar_o  (bar),
        .last_o (last_pix)
    );

    // busy drops in the DONE cycle so it falls together with the done pulse.
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 SHALL have parameter H_RES, default 240, meaning active columns.
REQ-002 SHALL have parameter V_RES, default 280, meaning active rows.
REQ-003 SHALL have parameter Y_OFS, default 20, meaning panel row offset added to RASET addresses.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  single-cycle request to write one full frame.
REQ-007 SHALL have port pattern  in  1  0 = solid fill, 1 = eight vertical colour bars.
REQ-008 SHALL have port color  in  16  RGB565 fill colour for solid mode.
REQ-009 SHALL have port valid  out  1  byte available to the downstream FIFO.
REQ-010 SHALL have port ready  in  1  FIFO can accept a byte (FIFO wr_ready).
REQ-011 SHALL have port data  out  8  byte to write.
REQ-012 SHALL have port is_cmd  out  1  high when data is a command byte, low for parameter/pixel bytes.
REQ-013 SHALL have port busy  out  1  high from the cycle after accepted start until done.
REQ-014 SHALL have port done  out  1  one-cycle pulse after the final pixel byte transfers.

Function
REQ-015 SHALL implement states IDLE, CASET_C, CASET_D, RASET_C, RASET_D, RAMWR_C, PIX_HI, PIX_LO, DONE.
REQ-016 SHALL leave IDLE only on start=1, latching pattern and color in that cycle.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL transfer a byte only in a cycle with valid=1 and ready=1, and advance state/counters only on that transfer.
REQ-019 SHALL hold data and is_cmd stable while valid=1 and ready=0, and SHALL NOT deassert valid before the transfer.
REQ-020 SHALL drive valid combinationally from state (no bubble between consecutive bytes when ready stays high): one byte per cycle at full throughput.
REQ-021 SHALL emit, in order: 0x2A; bytes 0x00,0x00,(H_RES-1)[15:8],(H_RES-1)[7:0]; 0x2B; Y_OFS[15:8],Y_OFS[7:0],(Y_OFS+V_RES-1)[15:8],(Y_OFS+V_RES-1)[7:0]; 0x2C; then H_RES*V_RES pixels, each as high byte then low byte.
REQ-022 SHALL use a 2-bit parameter-byte index in CASET_D/RASET_D, wrapping 3->0 on exit.
REQ-023 SHALL scan pixels column-first: col 0..H_RES-1, then row increments; col wraps to 0 at H_RES-1; frame ends at col=H_RES-1, row=V_RES-1.
REQ-024 SHALL in bar mode select colour from an 8-entry RGB565 table indexed by a bar counter that increments every H_RES/8 columns and resets to 0 at each new row, using a counter, not a divider.
REQ-025 SHALL enter DONE after the PIX_LO transfer of the last pixel, pulse done=1 for exactly that one cycle, then return to IDLE with busy=0.
REQ-026 SHALL accept a new start in the cycle after DONE.

Reset
REQ-027 SHALL on rst=1, regardless of clk, force state IDLE, valid=0, busy=0, done=0, data=0x00, is_cmd=0, all counters 0.
REQ-028 SHALL on rst mid-frame abandon the frame with no further bytes emitted; the next start restarts from 0x2A.

Structure
REQ-029 SHALL place in a shared package: command opcodes (CASET 0x2A, RASET 0x2B, RAMWR 0x2C), the state typedef, and the 8-entry bar colour table (white, yellow, cyan, green, magenta, red, blue, black).
REQ-030 SHALL implement as a single module; the pixel column/row/bar counter MAY be split into a sub-module named lcd_pixel_scan.

Verification
REQ-031 SHALL verify header: H_RES=240,V_RES=280,Y_OFS=20, ready=1, start -> first 11 bytes 2A,00,00,00,EF,2B,00,14,01,2B,2C with is_cmd=1 only on 2A,2B,2C.
REQ-032 SHALL verify solid fill: color=0xF800 -> exactly 134400 pixel bytes alternating F8,00, then done pulses once, busy falls same cycle.
REQ-033 SHALL verify bars: pattern=1 -> row 0 cols 0..29 = 0xFFFF, col 30 = 0xFFE0, col 239 = 0x0000; col 0 of row 1 = 0xFFFF again.
REQ-034 SHALL verify backpressure: random ready (50%) -> byte sequence identical to ready=1 run, no data change while valid&!ready.
REQ-035 SHALL verify start during busy ignored and rst asserted at pixel 1000 -> valid=0 immediately; next start re-emits 0x2A first.
REQ-036 SHALL verify small config H_RES=8,V_RES=2: done after exactly 11+32 transfers, back-to-back start accepted cycle after done.
